// File: rtl/imm_ext_arbiter.sv
// Shared 16->32 immediate extender with two requesters.
// Requests are arbitrated round-robin, or by fixed priority with requester 0
// winning. The result sits in a one-entry registered buffer that drives a
// valid/ready response channel tagged with the requester id.
module imm_ext_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [15:0] req0_imm,
    input  logic [1:0]  req0_mode,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [15:0] req1_imm,
    input  logic [1:0]  req1_mode,
    output logic        req1_ready,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_id,
    input  logic        resp_ready,
    output logic        err_mode
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_e;

    localparam logic [1:0] MODE_SIGN  = 2'b00;
    localparam logic [1:0] MODE_ZERO  = 2'b01;
    localparam logic [1:0] MODE_UPPER = 2'b10;
    localparam logic [1:0] MODE_RSVD  = 2'b11;

    buf_state_e  state, state_nxt;
    logic        last_grant;
    logic        can_accept;
    logic        gnt0, gnt1;
    logic        accept;
    logic [15:0] sel_imm;
    logic [1:0]  sel_mode;
    logic [31:0] ext;

    // The buffer can take a new result when it is empty or being drained.
    assign can_accept = (state == EMPTY) || resp_ready;

    // Grant selection; last_grant names the previous winner, so under
    // contention with round-robin the other requester goes next.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0_valid && req1_valid) begin
            if (RR_EN && !last_grant) gnt1 = 1'b1;
            else                      gnt0 = 1'b1;
        end else if (req0_valid) begin
            gnt0 = 1'b1;
        end else if (req1_valid) begin
            gnt1 = 1'b1;
        end
    end

    // Readies are forced low while reset is asserted.
    assign req0_ready = rst_n && can_accept && gnt0;
    assign req1_ready = rst_n && can_accept && gnt1;
    assign accept     = req0_ready || req1_ready;

    assign sel_imm  = gnt1 ? req1_imm  : req0_imm;
    assign sel_mode = gnt1 ? req1_mode : req0_mode;

    // Extension datapath; the reserved mode falls back to sign extension.
    always_comb begin
        ext = {{16{sel_imm[15]}}, sel_imm};
        case (sel_mode)
            MODE_ZERO:  ext = {16'h0000, sel_imm};
            MODE_UPPER: ext = {sel_imm, 16'h0000};
            default:    ext = {{16{sel_imm[15]}}, sel_imm};
        endcase
    end

    // Buffer occupancy: a consume together with an accept stays FULL with no bubble.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (accept) state_nxt = FULL;
            FULL:    if (resp_ready && !accept) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // State, result buffer, arbitration history and sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= EMPTY;
            resp_data  <= 32'h0;
            resp_id    <= 1'b0;
            last_grant <= 1'b1;
            err_mode   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                resp_data  <= ext;
                resp_id    <= gnt1;
                last_grant <= gnt1;
                if (sel_mode == MODE_RSVD) err_mode <= 1'b1;
            end
        end
    end

    assign resp_valid = (state == FULL);

endmodule
